// File: rtl/nlms_pkg.sv
// NLMS sequencer shared types and helpers.
// State encoding, operation codes and count clamping.
package nlms_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_FILT,
        S_DRAIN,
        S_ERR,
        S_UPD,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [1:0] OP_FILT = 2'b00;
    localparam logic [1:0] OP_NLMS = 2'b01;

    // Largest count a buffer of 2**log2_lim entries can hold.
    function automatic logic [16:0] cnt_limit(
        input int unsigned log2_lim
    );
        return 17'd1 << log2_lim;
    endfunction

    // Saturate a requested count at the buffer limit.
    function automatic logic [16:0] clamp_cnt(
        input logic [15:0] cnt,
        input int unsigned log2_lim
    );
        logic [16:0] lim;
        lim = cnt_limit(log2_lim);
        return ({1'b0, cnt} > lim) ? lim : {1'b0, cnt};
    endfunction

endpackage

// File: rtl/nlms_idx_counter.sv
// Loadable up-counter with clear, enable and terminal flag.
// tc is high while the count equals the programmed last value.
module nlms_idx_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear beats load beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (ld) begin
            cnt_d = ld_val;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == last);

endmodule

// File: rtl/nlms_seq_ctrl.sv
// NLMS filter/adapt sequencer: per-sample push, MAC, drain,
// optional error and update passes, then result write.
module nlms_seq_ctrl
    import nlms_pkg::*;
#(
    parameter int LOG2_X_D_BUFF_HEIGHT = 7,
    parameter int LOG2_H_BUFF_HEIGHT   = 7,
    parameter int LOG2_NUM_MULS        = 2,
    parameter int MAC_LATENCY          = 2
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic                                        abort,
    input  logic [1:0]                                  operation,
    input  logic [15:0]                                 x_samples_count,
    input  logic [15:0]                                 h_blocks_count,
    output logic [LOG2_X_D_BUFF_HEIGHT-1:0]             x_idx,
    output logic [LOG2_H_BUFF_HEIGHT-LOG2_NUM_MULS-1:0] h_blk_idx,
    output logic                                        fifo_push,
    output logic                                        mac_clr,
    output logic                                        mac_en,
    output logic                                        err_calc,
    output logic                                        upd_en,
    output logic                                        out_we,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        cfg_err
);

    localparam int XW = LOG2_X_D_BUFF_HEIGHT;
    localparam int HW = LOG2_H_BUFF_HEIGHT - LOG2_NUM_MULS;
    localparam int DW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    state_e        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [XW-1:0] samp_last_q, samp_last_d;
    logic [HW-1:0] blk_last_q, blk_last_d;
    logic          cfg_err_q, cfg_err_d;
    logic [DW-1:0] drain_q, drain_d;

    logic [16:0]   samp_cl;
    logic [16:0]   blk_cl;
    logic          x_ld, x_en, x_clr;
    logic          blk_run;
    logic          samp_tc, blk_tc;
    logic [XW-1:0] x_cnt;
    logic [HW-1:0] h_cnt;

    logic fifo_push_q, mac_clr_q, mac_en_q, err_calc_q;
    logic upd_en_q, out_we_q, busy_q, done_q;

    assign samp_cl = clamp_cnt(x_samples_count, XW);
    assign blk_cl  = clamp_cnt(h_blocks_count, HW);

    // Next-state, config latch and sample counter controls.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        samp_last_d = samp_last_q;
        blk_last_d  = blk_last_q;
        cfg_err_d   = cfg_err_q;
        x_ld        = 1'b0;
        x_en        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    op_d        = operation;
                    samp_last_d = XW'(samp_cl - 17'd1);
                    blk_last_d  = HW'(blk_cl - 17'd1);
                    x_ld        = 1'b1;
                    if (operation[1]) begin
                        cfg_err_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        cfg_err_d = 1'b0;
                        if (samp_cl == '0 || blk_cl == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_PUSH;
                        end
                    end
                end
            end
            S_PUSH: state_d = S_FILT;
            S_FILT: begin
                if (blk_tc) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_q == DW'(MAC_LATENCY - 1)) begin
                    state_d = (op_q == OP_NLMS) ? S_ERR : S_WRITE;
                end
            end
            S_ERR: state_d = S_UPD;
            S_UPD: begin
                if (blk_tc) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (samp_tc) begin
                    state_d = S_DONE;
                end else begin
                    x_en    = 1'b1;
                    state_d = S_PUSH;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            x_en    = 1'b0;
        end
    end

    assign x_clr   = (state_d == S_IDLE) || (state_d == S_DONE);
    assign blk_run = (state_d == state_q) &&
                     (state_q == S_FILT || state_q == S_UPD);

    // Drain cycle counter, restarted on every entry to DRAIN.
    always_comb begin
        drain_d = '0;
        if (state_d == S_DRAIN && state_q == S_DRAIN) begin
            drain_d = drain_q + DW'(1);
        end
    end

    // State, latched config and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            samp_last_q <= '0;
            blk_last_q  <= '0;
            cfg_err_q   <= 1'b0;
            drain_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            samp_last_q <= samp_last_d;
            blk_last_q  <= blk_last_d;
            cfg_err_q   <= cfg_err_d;
            drain_q     <= drain_d;
        end
    end

    // Strobes decoded from the next state and registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_push_q <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_en_q    <= 1'b0;
            err_calc_q  <= 1'b0;
            upd_en_q    <= 1'b0;
            out_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            fifo_push_q <= (state_d == S_PUSH);
            mac_clr_q   <= (state_d == S_PUSH);
            mac_en_q    <= (state_d == S_FILT);
            err_calc_q  <= (state_d == S_ERR);
            upd_en_q    <= (state_d == S_UPD);
            out_we_q    <= (state_d == S_WRITE);
            busy_q      <= (state_d != S_IDLE) &&
                           (state_d != S_DONE);
            done_q      <= (state_d == S_DONE);
        end
    end

    nlms_idx_counter #(.W(XW)) u_samp_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (x_clr),
        .ld     (x_ld),
        .ld_val ('0),
        .en     (x_en),
        .last   (samp_last_q),
        .cnt    (x_cnt),
        .tc     (samp_tc)
    );

    nlms_idx_counter #(.W(HW)) u_blk_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!blk_run),
        .ld     (1'b0),
        .ld_val ('0),
        .en     (blk_run),
        .last   (blk_last_q),
        .cnt    (h_cnt),
        .tc     (blk_tc)
    );

    assign x_idx     = x_cnt;
    assign h_blk_idx = h_cnt;
    assign fifo_push = fifo_push_q;
    assign mac_clr   = mac_clr_q;
    assign mac_en    = mac_en_q;
    assign err_calc  = err_calc_q;
    assign upd_en    = upd_en_q;
    assign out_we    = out_we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule
